// File: rtl/idli_fetch_m.sv
// Instruction fetch: runs SQI read transactions and streams instruction nibbles to the decoder.
// Define IDLI_FETCH_PERF_EN to add the saturating redirect counter output o_fetch_redir_cnt.
`timescale 1ns/1ps
module idli_fetch_m #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int unsigned DUMMY_CYCLES = 2
) (
    input  logic        i_fetch_gck,
    input  logic        i_fetch_rst_n,
    input  logic        i_fetch_redir,
    input  logic [15:0] i_fetch_redir_pc,
    output logic        o_fetch_mem_cs_n,
    output logic [3:0]  o_fetch_mem_sio,
    output logic [3:0]  o_fetch_mem_oe,
    input  logic [3:0]  i_fetch_mem_sio,
    output logic [3:0]  o_fetch_enc,
    output logic        o_fetch_enc_vld,
    output logic [15:0] o_fetch_pc
`ifdef IDLI_FETCH_PERF_EN
    ,
    output logic [7:0]  o_fetch_redir_cnt
`endif
);

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData} state_t;

    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

    state_t      state_q;
    logic [2:0]  step_q;
    logic [1:0]  nib_q;
    logic [15:0] pc_q;
    logic        cs_n_q;
    logic [3:0]  sio_q;
    logic [3:0]  oe_q;
    logic [3:0]  enc_q;
    logic        vld_q;

    logic [1:0]  addr_idx;
    logic [15:0] addr_sh;

    // Address nibble to drive on the next ADDR cycle, MS nibble first.
    always_comb begin
        addr_idx = step_q[1:0] + 2'd1;
        addr_sh  = pc_q << {addr_idx, 2'b00};
    end

    always_ff @(posedge i_fetch_gck or negedge i_fetch_rst_n) begin
        if (!i_fetch_rst_n) begin
            state_q <= StIdle;
            step_q  <= 3'd0;
            nib_q   <= 2'd0;
            pc_q    <= RESET_PC;
            cs_n_q  <= 1'b1;
            sio_q   <= 4'h0;
            oe_q    <= 4'h0;
            enc_q   <= 4'h0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (i_fetch_redir) begin
                pc_q   <= i_fetch_redir_pc;
                nib_q  <= 2'd0;
                step_q <= 3'd0;
                // IDLE already gave the memory its cs_n high cycle, so go straight on.
                if (state_q == StIdle) begin
                    state_q <= StCmd;
                    cs_n_q  <= 1'b0;
                    oe_q    <= 4'hF;
                    sio_q   <= 4'hE;
                end else begin
                    state_q <= StIdle;
                    cs_n_q  <= 1'b1;
                    oe_q    <= 4'h0;
                    sio_q   <= 4'h0;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q <= StCmd;
                        step_q  <= 3'd0;
                        cs_n_q  <= 1'b0;
                        oe_q    <= 4'hF;
                        sio_q   <= 4'hE;
                    end
                    StCmd: begin
                        if (step_q == 3'd0) begin
                            step_q <= 3'd1;
                            sio_q  <= 4'hB;
                        end else begin
                            state_q <= StAddr;
                            step_q  <= 3'd0;
                            sio_q   <= pc_q[15:12];
                        end
                    end
                    StAddr: begin
                        if (step_q == 3'd3) begin
                            state_q <= StDummy;
                            step_q  <= 3'd0;
                            oe_q    <= 4'h0;
                            sio_q   <= 4'h0;
                        end else begin
                            step_q <= step_q + 3'd1;
                            sio_q  <= addr_sh[15:12];
                        end
                    end
                    StDummy: begin
                        if (step_q == DUMMY_LAST) begin
                            state_q <= StData;
                            step_q  <= 3'd0;
                        end else begin
                            step_q <= step_q + 3'd1;
                        end
                    end
                    StData: begin
                        enc_q <= i_fetch_mem_sio;
                        vld_q <= 1'b1;
                        nib_q <= nib_q + 2'd1;
                        // Memory streams sequentially, so pc simply wraps with it.
                        if (nib_q == 2'd3) begin
                            pc_q <= pc_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cs_n_q  <= 1'b1;
                        oe_q    <= 4'h0;
                        sio_q   <= 4'h0;
                    end
                endcase
            end
        end
    end

    assign o_fetch_mem_cs_n = cs_n_q;
    assign o_fetch_mem_sio  = sio_q;
    assign o_fetch_mem_oe   = oe_q;
    assign o_fetch_enc      = enc_q;
    assign o_fetch_enc_vld  = vld_q;
    assign o_fetch_pc       = pc_q;

`ifdef IDLI_FETCH_PERF_EN
    logic [7:0] redir_cnt_q;

    always_ff @(posedge i_fetch_gck or negedge i_fetch_rst_n) begin
        if (!i_fetch_rst_n) begin
            redir_cnt_q <= 8'h00;
        end else if (i_fetch_redir && (redir_cnt_q != 8'hFF)) begin
            redir_cnt_q <= redir_cnt_q + 8'd1;
        end
    end

    assign o_fetch_redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_idli_fetch_m.sv
// Bench for idli_fetch_m: two instances (DUMMY_CYCLES 2 and 4) against an SQI memory and a
// transaction-level model of the expected nibble stream.
`timescale 1ns/1ps
module tb_idli_fetch_m;

    logic        gck;
    logic        rst_n;
    logic        redir;
    logic [15:0] redir_pc;

    logic        cs_n   [2];
    logic [3:0]  sio_o  [2];
    logic [3:0]  oe     [2];
    logic [3:0]  sio_i  [2];
    logic [3:0]  enc    [2];
    logic        vld    [2];
    logic [15:0] pc     [2];
`ifdef IDLI_FETCH_PERF_EN
    logic [7:0]  rcnt   [2];
`endif

    int n_pass = 0;
    int n_tot  = 0;

    initial gck = 1'b0;
    always #5 gck = ~gck;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        idli_fetch_m #(
            .RESET_PC     (16'h0000),
            .DUMMY_CYCLES ((g == 0) ? 2 : 4)
        ) u_dut (
            .i_fetch_gck      (gck),
            .i_fetch_rst_n    (rst_n),
            .i_fetch_redir    (redir),
            .i_fetch_redir_pc (redir_pc),
            .o_fetch_mem_cs_n (cs_n[g]),
            .o_fetch_mem_sio  (sio_o[g]),
            .o_fetch_mem_oe   (oe[g]),
            .i_fetch_mem_sio  (sio_i[g]),
            .o_fetch_enc      (enc[g]),
            .o_fetch_enc_vld  (vld[g]),
            .o_fetch_pc       (pc[g])
`ifdef IDLI_FETCH_PERF_EN
            ,
            .o_fetch_redir_cnt (rcnt[g])
`endif
        );
    end

    function automatic int dum(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1234;
            16'h0001: return 16'h5678;
            default:  return {a[7:0], ~a[15:8]};
        endcase
    endfunction

    function automatic logic [3:0] nib_of(input logic [15:0] w, input int idx);
        logic [15:0] sh;
        sh = w >> (4 * (3 - idx));
        return sh[3:0];
    endfunction

    task automatic check(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, want %h at %0t", nm, inst, act, exp, $time);
    endtask

    // SQI memory: captures command and address, then streams words sequentially.
    int          mc    [2];
    logic [15:0] maddr [2];
    logic [7:0]  mcmd  [2];

    always @(negedge gck) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_n[i] !== 1'b0) begin
                mc[i]    <= 0;
                sio_i[i] <= 4'h0;
            end else begin
                if (mc[i] < 2) mcmd[i] <= {mcmd[i][3:0], sio_o[i]};
                if (mc[i] >= 2 && mc[i] <= 5) maddr[i] <= {maddr[i][11:0], sio_o[i]};
                if (mc[i] >= 6 + dum(i))
                    sio_i[i] <= nib_of(mem_word(maddr[i] + 16'((mc[i] - 6 - dum(i)) / 4)),
                                       (mc[i] - 6 - dum(i)) % 4);
                else
                    sio_i[i] <= 4'h0;
                mc[i] <= mc[i] + 1;
            end
        end
    end

    // Model: t counts cycles since the stream (re)started, t == 0 being the cs_n-high cycle.
    int          mt     [2];
    logic [15:0] mstart [2];
    int          mrc    [2];

    always @(posedge gck or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mt[i]     <= 0;
                mstart[i] <= 16'h0000;
                mrc[i]    <= 0;
            end else if (redir) begin
                mstart[i] <= redir_pc;
                mt[i]     <= (mt[i] == 0) ? 1 : 0;
                mrc[i]    <= (mrc[i] < 255) ? mrc[i] + 1 : 255;
            end else begin
                mt[i] <= mt[i] + 1;
            end
        end
    end

    always @(negedge gck) begin
        int          t;
        int          k;
        logic        e_vld;
        logic [3:0]  e_sio;
        logic [15:0] e_pc;
        for (int i = 0; i < 2; i++) begin
            t = mt[i];
            case (t)
                1:          e_sio = 4'hE;
                2:          e_sio = 4'hB;
                3, 4, 5, 6: e_sio = nib_of(mstart[i], t - 3);
                default:    e_sio = 4'h0;
            endcase
            e_vld = (t >= 8 + dum(i));
            k     = t - 8 - dum(i);
            e_pc  = e_vld ? mstart[i] + 16'((k + 1) / 4) : mstart[i];
            check("cs_n", i, 32'(cs_n[i]), 32'(t == 0));
            check("oe", i, 32'(oe[i]), (t >= 1 && t <= 6) ? 32'hF : 32'h0);
            check("sio", i, 32'(sio_o[i]), 32'(e_sio));
            check("vld", i, 32'(vld[i]), 32'(e_vld));
            check("pc", i, 32'(pc[i]), 32'(e_pc));
            if (e_vld)
                check("enc", i, 32'(enc[i]),
                      32'(nib_of(mem_word(mstart[i] + 16'(k / 4)), k % 4)));
`ifdef IDLI_FETCH_PERF_EN
            check("redir_cnt", i, 32'(rcnt[i]), 32'(mrc[i]));
`endif
        end
    end

    task automatic pulse_redir(input logic [15:0] a);
        @(posedge gck);
        #1 redir = 1'b1;
        redir_pc = a;
        @(posedge gck);
        #1 redir = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b1;
        redir    = 1'b0;
        redir_pc = 16'h0000;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge gck);
        for (int i = 0; i < 2; i++) begin
            check("rst_cs_n", i, 32'(cs_n[i]), 32'h1);
            check("rst_enc", i, 32'(enc[i]), 32'h0);
            check("rst_vld", i, 32'(vld[i]), 32'h0);
`ifdef IDLI_FETCH_PERF_EN
            check("rst_rcnt", i, 32'(rcnt[i]), 32'h0);
`endif
        end
        rst_n = 1'b1;

        // First transaction from reset: t counts negedges after the IDLE cycle.
        for (int t = 1; t <= 18; t++) begin
            @(negedge gck);
            case (t)
                1:  begin check("h_cs_n", 0, 32'(cs_n[0]), 32'h0);
                          check("h_cmd_e", 0, 32'(sio_o[0]), 32'hE); end
                2:  check("h_cmd_b", 0, 32'(sio_o[0]), 32'hB);
                3, 4, 5, 6: check("h_addr", 0, 32'(sio_o[0]), 32'h0);
                7, 8, 10: check("h_dummy_oe", 1, 32'(oe[1]), 32'h0);
                9:  begin check("h_vld_early", 0, 32'(vld[0]), 32'h0);
                          check("h_dummy_oe", 1, 32'(oe[1]), 32'h0); end
                11: check("h_vld_early", 1, 32'(vld[1]), 32'h0);
                12: begin check("h_vld_first", 1, 32'(vld[1]), 32'h1);
                          check("h_enc_first", 1, 32'(enc[1]), 32'h1); end
                13: begin check("h_enc4", 0, 32'(enc[0]), 32'h4);
                          check("h_pc1", 0, 32'(pc[0]), 32'h1); end
                17: begin check("h_enc8", 0, 32'(enc[0]), 32'h8);
                          check("h_pc2", 0, 32'(pc[0]), 32'h2); end
                default: ;
            endcase
            if (t == 10) begin
                check("h_vld_first", 0, 32'(vld[0]), 32'h1);
                check("h_enc_first", 0, 32'(enc[0]), 32'h1);
            end
        end
        check("h_mem_cmd", 0, 32'(mcmd[0]), 32'hEB);
        check("h_mem_addr", 0, 32'(maddr[0]), 32'h0000);

        // Redirect on the second nibble of a word.
        @(posedge gck);
        #1 redir = 1'b1;
        redir_pc = 16'hABCD;
        @(posedge gck);
        #1 redir = 1'b0;
        @(negedge gck);
        check("h_redir_vld", 0, 32'(vld[0]), 32'h0);
        check("h_redir_cs_n", 0, 32'(cs_n[0]), 32'h1);
        check("h_redir_pc", 0, 32'(pc[0]), 32'hABCD);
        repeat (20) @(negedge gck);
        check("h_mem_addr", 0, 32'(maddr[0]), 32'hABCD);

        // Redirect during ADDR, then again in the IDLE cycle that follows.
        pulse_redir(16'h2222);
        repeat (3) @(posedge gck);
        #1 redir = 1'b1;
        redir_pc = 16'h5555;
        @(posedge gck);
        #1 redir_pc = 16'h0010;
        @(posedge gck);
        #1 redir = 1'b0;
        repeat (20) @(negedge gck);
        check("h_mem_addr", 0, 32'(maddr[0]), 32'h0010);
        check("h_mem_addr", 1, 32'(maddr[1]), 32'h0010);

        // Stream across the top of the address space.
        pulse_redir(16'hFFFF);
        for (int t = 0; t <= 16; t++) begin
            @(negedge gck);
            if (t == 13) begin
                check("h_wrap_pc", 0, 32'(pc[0]), 32'h0000);
                check("h_wrap_enc", 0, 32'(enc[0]), 32'h0);
            end
            if (t == 14) check("h_wrap_enc", 0, 32'(enc[0]), 32'h1);
            if (t == 16) begin
                check("h_wrap_cs_n", 0, 32'(cs_n[0]), 32'h0);
                check("h_wrap_oe", 0, 32'(oe[0]), 32'h0);
            end
        end

`ifdef IDLI_FETCH_PERF_EN
        @(posedge gck);
        #1 redir = 1'b1;
        redir_pc = 16'h0000;
        repeat (300) @(posedge gck);
        #1 redir = 1'b0;
        @(negedge gck);
        check("h_rcnt_sat", 0, 32'(rcnt[0]), 32'hFF);
        repeat (14) @(negedge gck);
`endif

        // Asynchronous reset while streaming.
        @(posedge gck);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("h_arst_cs_n", i, 32'(cs_n[i]), 32'h1);
            check("h_arst_oe", i, 32'(oe[i]), 32'h0);
            check("h_arst_vld", i, 32'(vld[i]), 32'h0);
            check("h_arst_enc", i, 32'(enc[i]), 32'h0);
            check("h_arst_pc", i, 32'(pc[i]), 32'h0000);
`ifdef IDLI_FETCH_PERF_EN
            check("h_arst_rcnt", i, 32'(rcnt[i]), 32'h0);
`endif
        end
        @(negedge gck);
        rst_n = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            @(negedge gck);
            if (t == 10) begin
                check("h_restart_vld", 0, 32'(vld[0]), 32'h1);
                check("h_restart_enc", 0, 32'(enc[0]), 32'h1);
            end
        end
        check("h_mem_addr", 0, 32'(maddr[0]), 32'h0000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
